// File: rtl/alu_arb_pkg.sv
// Shared definitions for the time-shared ALU arbiter: FSM states,
// requester IDs and the ALUop encodings understood by the alu block.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd10;

endpackage

// File: rtl/alu.sv
// Existing 32-bit combinational ALU: result = a <op> b, flag = (result == 0).
module alu
  import alu_arb_pkg::*;
(
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic [ALUOP_W-1:0] ALUop,
  output logic [31:0]        result,
  output logic               flag
);

  logic [31:0] w_sra;

  assign w_sra = $signed(a) >>> b[4:0];

  // Operation select; unknown opcodes produce zero.
  always_comb begin
    result = 32'd0;
    case (ALUop)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = w_sra;
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      ALU_NOR:  result = ~(a | b);
      default:  result = 32'd0;
    endcase
  end

  assign flag = (result == 32'd0);

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for a single shared ALU.
// One transaction at a time: accept in IDLE, compute in EXEC, hand the
// registered result to the owner in RESP.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,  // must match the 32-bit alu
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [OP_W-1:0]   req1_op_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_flag_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  cnt0_o,
  output logic [CNT_W-1:0]  cnt1_o
);

  state_t            r_state;
  logic              r_last;
  logic              r_owner;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_result;
  logic              r_flag;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_hs;
  logic              w_hs_id;
  logic              w_rsp_take;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_flag;

  // Round-robin grant: a lone requester wins; on a tie the one that did not go last wins.
  always_comb begin
    w_grant0 = req0_valid_i;
    w_grant1 = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      w_grant0 = (r_last == REQ1);
      w_grant1 = (r_last == REQ0);
    end
  end

  assign req0_ready_o = (r_state == IDLE) && w_grant0;
  assign req1_ready_o = (r_state == IDLE) && w_grant1;
  assign w_hs         = req0_ready_o || req1_ready_o;
  assign w_hs_id      = req1_ready_o ? REQ1 : REQ0;
  // Only the owner's response ready can close a transaction.
  assign w_rsp_take   = (r_owner == REQ1) ? rsp1_ready_i : rsp0_ready_i;

  // The ALU only ever sees the latched operands, never the live request buses.
  alu u_alu (
    .a      (r_a),
    .b      (r_b),
    .ALUop  (r_op),
    .result (w_alu_result),
    .flag   (w_alu_flag)
  );

  // Sequencer FSM with registered response/busy outputs and completion counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= REQ1;
      r_owner      <= REQ0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_flag       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_a     <= (w_hs_id == REQ1) ? req1_a_i  : req0_a_i;
            r_b     <= (w_hs_id == REQ1) ? req1_b_i  : req0_b_i;
            r_op    <= (w_hs_id == REQ1) ? req1_op_i : req0_op_i;
            r_owner <= w_hs_id;
            r_last  <= w_hs_id;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result     <= w_alu_result;
          r_flag       <= w_alu_flag;
          r_rsp0_valid <= (r_owner == REQ0);
          r_rsp1_valid <= (r_owner == REQ1);
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_take) begin
            if (r_owner == REQ1) begin
              r_cnt1 <= r_cnt1 + CNT_W'(1);
            end else begin
              r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid_o = r_rsp0_valid;
  assign rsp1_valid_o = r_rsp1_valid;
  assign rsp_result_o = r_result;
  assign rsp_flag_o   = r_flag;
  assign busy_o       = r_busy;
  assign cnt0_o       = r_cnt0;
  assign cnt1_o       = r_cnt1;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, single op, zero flag, tie
// round-robin, response backpressure, mid-operation reset, counter wrap.
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_ready, rsp1_ready;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_flag, busy;
  logic [31:0] rsp_result;
  logic [15:0] cnt0, cnt1;

  logic        w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_flag, w_busy;
  logic [31:0] w_result;
  logic [1:0]  w_cnt0, w_cnt1;

  int checks;
  int failures;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
    .rsp_result_o(rsp_result), .rsp_flag_o(rsp_flag),
    .busy_o(busy), .cnt0_o(cnt0), .cnt1_o(cnt1)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check.
  alu_share_arb #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(w_req0_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
    .req1_valid_i(req1_valid), .req1_ready_o(w_req1_ready),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
    .rsp0_valid_o(w_rsp0_valid), .rsp0_ready_i(rsp0_ready),
    .rsp1_valid_o(w_rsp1_valid), .rsp1_ready_i(rsp1_ready),
    .rsp_result_o(w_result), .rsp_flag_o(w_flag),
    .busy_o(w_busy), .cnt0_o(w_cnt0), .cnt1_o(w_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on posedge+1; all checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flag, busy, cnt0, cnt1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b%b vld=%b%b res=%h flag=%b busy=%b cnt=%0d/%0d required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flag, busy, cnt0, cnt1);
    end
    checks++;
    if ({w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_result, w_flag, w_busy, w_cnt0, w_cnt1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_w: narrow instance outputs not all 0 (res=%h cnt=%0d/%0d)", w_result, w_cnt0, w_cnt1);
    end
    $display("txn reset done");
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_op = ALU_ADD;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: rdy0=%b rdy1=%b busy=%b required 1 0 0", req0_ready, req1_ready, busy);
    end
    step();
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || busy !== 1'b1 || rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_exec: rdy0=%b busy=%b vld0=%b required 0 1 0", req0_ready, busy, rsp0_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd8 || rsp_flag !== 1'b0) begin
      failures++;
      $display("FAIL single_resp: vld=%b%b res=%0d flag=%b required vld0=1 res=8 flag=0",
               rsp0_valid, rsp1_valid, rsp_result, rsp_flag);
    end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || cnt0 !== 16'd1 || cnt1 !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: vld0=%b cnt0=%0d cnt1=%0d busy=%b required 0 1 0 0", rsp0_valid, cnt0, cnt1, busy);
    end
    $display("txn single req0 5+3 res=%0d flag=%b cnt0=%0d", rsp_result, rsp_flag, cnt0);
  endtask

  task automatic test_zero_flag();
    bit saw_vld0;
    do_reset();
    saw_vld0 = 0;
    req1_valid = 1; req1_a = 32'd7; req1_b = 32'd7; req1_op = ALU_SUB;
    rsp0_ready = 1;
    @(negedge clk);
    saw_vld0 |= rsp0_valid;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_grant: rdy1=%b rdy0=%b required 1 0", req1_ready, req0_ready);
    end
    step();
    req1_valid = 0;
    @(negedge clk);
    saw_vld0 |= rsp0_valid;
    step();
    @(negedge clk);
    saw_vld0 |= rsp0_valid;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_flag !== 1'b1) begin
      failures++;
      $display("FAIL zero_resp: vld1=%b res=%h flag=%b required 1 0 1", rsp1_valid, rsp_result, rsp_flag);
    end
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    rsp0_ready = 0;
    @(negedge clk);
    saw_vld0 |= rsp0_valid;
    checks++;
    if (saw_vld0 !== 1'b0 || cnt1 !== 16'd1 || cnt0 !== 16'd0) begin
      failures++;
      $display("FAIL zero_done: saw_vld0=%b cnt1=%0d cnt0=%0d required 0 1 0", saw_vld0, cnt1, cnt0);
    end
    $display("txn zero req1 7-7 flag=1 cnt1=%0d", cnt1);
  endtask

  task automatic test_round_robin();
    bit found;
    logic [31:0] exp_res;
    do_reset();
    req0_valid = 1; req0_a = 32'd10;  req0_b = 32'd4;  req0_op = ALU_SUB;
    req1_valid = 1; req1_a = 32'hF0;  req1_b = 32'h3C; req1_op = ALU_AND;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int t = 0; t < 4; t++) begin
      found = 0;
      for (int k = 0; k < 16 && !found; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) found = 1;
        else step();
      end
      checks++;
      if (!found || req0_ready !== (t % 2 == 0) || req1_ready !== (t % 2 == 1)) begin
        failures++;
        $display("FAIL rr_grant_%0d: found=%b rdy0=%b rdy1=%b required owner %0d", t, found, req0_ready, req1_ready, t % 2);
      end
      step();
      step();
      @(negedge clk);
      exp_res = (t % 2 == 0) ? 32'd6 : 32'h30;
      checks++;
      if (rsp0_valid !== (t % 2 == 0) || rsp1_valid !== (t % 2 == 1) || rsp_result !== exp_res) begin
        failures++;
        $display("FAIL rr_resp_%0d: vld=%b%b res=%h required owner %0d res=%h", t, rsp0_valid, rsp1_valid, rsp_result, t % 2, exp_res);
      end
      $display("txn rr %0d owner=%0d res=%h", t, t % 2, rsp_result);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin
      failures++;
      $display("FAIL rr_counts: cnt0=%0d cnt1=%0d required 2 2", cnt0, cnt1);
    end
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = ALU_ADD;
    rsp0_ready = 0; rsp1_ready = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_grant0: rdy0=%b required 1", req0_ready);
    end
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'd6; req1_b = 32'd3; req1_op = ALU_OR;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_exec_rdy1: rdy1=%b required 0", req1_ready);
    end
    step();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_flag !== 1'b1 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: vld=%b%b res=%h flag=%b rdy1=%b required vld0=1 res=0 flag=1 rdy1=0",
                 c, rsp0_valid, rsp1_valid, rsp_result, rsp_flag, req1_ready);
      end
      step();
    end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0 || cnt0 !== 16'd1) begin
      failures++;
      $display("FAIL bp_release: rdy1=%b vld0=%b cnt0=%0d required 1 0 1", req1_ready, rsp0_valid, cnt0);
    end
    step();
    req1_valid = 0;
    step();
    @(negedge clk);
    checks++;
    if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== 32'd7 || rsp_flag !== 1'b0) begin
      failures++;
      $display("FAIL bp_resp1: vld=%b%b res=%0d flag=%b required vld1=1 res=7 flag=0", rsp0_valid, rsp1_valid, rsp_result, rsp_flag);
    end
    step();
    @(negedge clk);
    checks++;
    if (cnt1 !== 16'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: cnt1=%0d busy=%b required 1 0", cnt1, busy);
    end
    rsp1_ready = 0;
    $display("txn backpressure held 10 cycles then req1 res=7");
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req1_valid = 1; req1_a = 32'd9; req1_b = 32'd9; req1_op = ALU_ADD;
    step();
    req1_valid = 0;
    step();
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    @(negedge clk);
    checks++;
    if (cnt1 !== 16'd1 || rsp_result !== 32'd18) begin
      failures++;
      $display("FAIL mid_pre: cnt1=%0d res=%0d required 1 18", cnt1, rsp_result);
    end
    step();
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_op = ALU_ADD;
    step();
    req0_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flag, busy, cnt0, cnt1} !== '0) begin
      failures++;
      $display("FAIL mid_async: rdy=%b%b vld=%b%b res=%h flag=%b busy=%b cnt=%0d/%0d required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flag, busy, cnt0, cnt1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
        failures++;
        $display("FAIL mid_after_%0d: vld=%b%b busy=%b cnt=%0d/%0d required all 0", c, rsp0_valid, rsp1_valid, busy, cnt0, cnt1);
      end
    end
    step();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_first_tie: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
    $display("txn reset mid-EXEC aborted, tie goes to req0");
  endtask

  task automatic test_counter_wrap();
    do_reset();
    rsp0_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      req0_valid = 1; req0_a = i; req0_b = i; req0_op = ALU_ADD;
      @(negedge clk);
      step();
      req0_valid = 0;
      step();
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp_result !== 32'(2 * i) || w_rsp0_valid !== 1'b1 || w_result !== 32'(2 * i)) begin
        failures++;
        $display("FAIL wrap_resp_%0d: vld=%b/%b res=%0d/%0d required 1 %0d", i, rsp0_valid, w_rsp0_valid, rsp_result, w_result, 2 * i);
      end
      step();
      @(negedge clk);
      checks++;
      if (w_cnt0 !== 2'(i % 4) || cnt0 !== 16'(i)) begin
        failures++;
        $display("FAIL wrap_cnt_%0d: cnt0_w=%0d cnt0=%0d required %0d %0d", i, w_cnt0, cnt0, i % 4, i);
      end
      $display("txn wrap %0d cnt0_w=%0d cnt0=%0d", i, w_cnt0, cnt0);
      step();
    end
    rsp0_ready = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_zero_flag();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer that time-shares one instance of the existing 32-bit combinational `alu` (a, b, ALUop → result, flag).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block registers operands, runs the ALU for one cycle, registers result and flag, and routes the response to the owner.
- Sits between the decode/issue stages and the shared ALU.

Parameters:
- DATA_W, 32, operand/result width; must equal the `alu` width of 32.
- OP_W, 4, ALUop width.
- CNT_W, 16, width of the per-requester completed-transaction counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 operation accepted this cycle.
- req0_a_i, req0_b_i  in  DATA_W  requester 0 operands.
- req0_op_i  in  OP_W  requester 0 ALUop.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_op_i  as requester 0, for requester 1.
- rsp0_valid_o  out  1  response for requester 0 is valid.
- rsp0_ready_i  in  1  requester 0 takes the response.
- rsp1_valid_o, rsp1_ready_i  as rsp0, for requester 1.
- rsp_result_o  out  DATA_W  registered ALU result, shared by both response channels.
- rsp_flag_o  out  1  registered ALU flag (zero of the arithmetic/logic path).
- busy_o  out  1  high whenever the FSM is not in IDLE.
- cnt0_o, cnt1_o  out  CNT_W  completed responses per requester.

Behaviour:
- FSM states are IDLE, EXEC and RESP.
- Reset values:
  - state = IDLE.
  - All ready/valid outputs = 0.
  - rsp_result_o = 0, rsp_flag_o = 0.
  - cnt0_o = cnt1_o = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - Internal operand, op and owner-ID registers = 0.
- IDLE:
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the one ≠ last.
  - reqN_ready_o = (state==IDLE) & grantN, combinational, one-hot.
  - On handshake: latch a, b, op and owner ID; set last = owner; next state EXEC.
  - No valid requester: stay in IDLE.
- EXEC:
  - The ALU is driven only from the latched registers.
  - At the clock edge, capture result → rsp_result_o and flag → rsp_flag_o; next state RESP.
- RESP:
  - rsp<owner>_valid_o = 1; the other rsp valid stays 0.
  - rsp_result_o and rsp_flag_o are held stable while valid.
  - On rsp<owner>_ready_i = 1: increment cnt<owner> (wraps at 2^CNT_W−1 → 0); next state IDLE.
  - Otherwise hold indefinitely; there is no timeout.
- Latency:
  - Request handshake at edge E0; response valid from E1 + (one cycle later at E2 visible in RESP).
  - Precisely: rsp valid is asserted in the second cycle after the handshake cycle.
  - Minimum 3 cycles per transaction; no overlap between transactions.
- Requester rules:
  - Requesters must hold valid and payload stable until ready.
  - If a valid is dropped before grant, it is simply not granted; the arbiter makes no claim about it.
- reqN_ready_o is 0 in EXEC and RESP, even while reqN_valid_i is high.
- The response-channel ready of the non-owner is ignored.
- Asserting rst_n low in EXEC or RESP aborts the in-flight operation: no response, no counter update, all outputs return to reset values asynchronously.
- Only rst_n resets counters; there is no separate clear.

Decomposition:
- Shared package `alu_arb_pkg` holds:
  - the state enum (IDLE/EXEC/RESP);
  - requester-ID constants REQ0 = 0 and REQ1 = 1;
  - the ALUop width constant;
  - named ALUop encodings used by benches.
- Sub-module: the existing `alu`, instantiated once; no new sub-module.
- Round-robin grant logic stays inline.

Test Plan:
- Reset then single request: req0 a=5, b=3, op=ADD (4'b0000) → req0_ready_o pulses once; rsp0_valid_o high 2 cycles later with result=8, flag=0; rsp0_ready_i=1 → cnt0_o=1, busy_o=0 next cycle.
- Zero flag: req1 a=7, b=7, op=SUB (4'b0001) → rsp1_valid_o with result=0, flag=1; rsp0_valid_o stays 0 throughout.
- Tie round-robin: both valid continuously with distinct ops → grant order 0,1,0,1 over 4 transactions; cnt0_o=2, cnt1_o=2.
- Backpressure: hold rsp0_ready_i=0 for 10 cycles → rsp0_valid_o, result and flag stable; req1_ready_o=0 throughout despite req1_valid_i=1; release → req1 is granted next IDLE cycle.
- Reset mid-operation: assert rst_n=0 during EXEC → all outputs 0 immediately; after release no response appears; counters = 0; first tie goes to requester 0.
- Counter wrap: with CNT_W=2, complete 4 req0 transactions → cnt0_o sequence 1,2,3,0.
